// File: rtl/text_memory_ctrl_pkg.sv
// Shared constants, state encoding and width helpers for the text-mode video memory.
package text_memory_ctrl_pkg;

    localparam int COLS_DEF    = 80;
    localparam int ROWS_DEF    = 30;
    localparam int ENTRY_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCROLL = 2'd2
    } fill_state_e;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/text_memory_ctrl_if.sv
// Host read/write port of the text memory.
interface text_memory_ctrl_if
    import text_memory_ctrl_pkg::*;
#(
    parameter int COLS    = COLS_DEF,
    parameter int ROWS    = ROWS_DEF,
    parameter int ENTRY_W = ENTRY_W_DEF
) ();
    localparam int XW = coord_w(COLS);
    localparam int YW = coord_w(ROWS);

    // A request transfers on a clock edge where host_req && host_ready. A read
    // answers with a one-cycle host_rvalid pulse on the following cycle;
    // host_rdata then holds until the next read answer.
    logic               host_req;
    logic               host_we;
    logic [XW-1:0]      host_x;
    logic [YW-1:0]      host_y;
    logic [ENTRY_W-1:0] host_wdata;
    logic               host_ready;
    logic [ENTRY_W-1:0] host_rdata;
    logic               host_rvalid;

    modport master (
        output host_req, host_we, host_x, host_y, host_wdata,
        input  host_ready, host_rdata, host_rvalid
    );

    modport slave (
        input  host_req, host_we, host_x, host_y, host_wdata,
        output host_ready, host_rdata, host_rvalid
    );
endinterface

// File: rtl/text_dpram.sv
// True dual-port RAM: port A read-only, port B read/write, both with registered reads.
module text_dpram #(
    parameter int ENTRY_W = 24,
    parameter int DEPTH   = 2400,
    parameter int AW      = 12
) (
    input  logic               clk,
    input  logic [AW-1:0]      a_addr,
    output logic [ENTRY_W-1:0] a_rdata_q,
    input  logic               b_en,
    input  logic               b_we,
    input  logic [AW-1:0]      b_addr,
    input  logic [ENTRY_W-1:0] b_wdata,
    output logic [ENTRY_W-1:0] b_rdata_q
);
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        a_rdata_q <= mem_q[a_addr];
    end

    // Port B read data only moves on a read, so it holds across writes.
    always_ff @(posedge clk) begin
        if (b_en) begin
            if (b_we) mem_q[b_addr] <= b_wdata;
            else      b_rdata_q     <= mem_q[b_addr];
        end
    end
endmodule

// File: rtl/text_memory_ctrl.sv
// Text-mode video memory: scrolled display read port, host port and clear/scroll fill engine.
module text_memory_ctrl
    import text_memory_ctrl_pkg::*;
#(
    parameter int                 COLS       = COLS_DEF,
    parameter int                 ROWS       = ROWS_DEF,
    parameter int                 ENTRY_W    = ENTRY_W_DEF,
    parameter logic [ENTRY_W-1:0] FILL_VALUE = '0,
    localparam int                XW         = coord_w(COLS),
    localparam int                YW         = coord_w(ROWS),
    localparam int                AW         = coord_w(COLS * ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XW-1:0]       xtext,
    input  logic [YW-1:0]       ytext,
    output logic [ENTRY_W-1:0]  entry,
    text_memory_ctrl_if.slave   host,
    input  logic                cmd_clear,
    input  logic                cmd_scroll,
    output logic                busy,
    output logic [YW-1:0]       scroll,
    output fill_state_e         dbg_state
);
    localparam int              CELLS     = COLS * ROWS;
    localparam logic [AW-1:0]   COLS_A    = AW'(COLS);
    localparam logic [AW-1:0]   LAST_CELL = AW'(CELLS - 1);
    localparam logic [XW:0]     COLS_X    = (XW + 1)'(COLS);
    localparam logic [YW:0]     ROWS_S    = (YW + 1)'(ROWS);
    localparam logic [XW-1:0]   LAST_COL  = XW'(COLS - 1);
    localparam logic [YW-1:0]   LAST_ROW  = YW'(ROWS - 1);

    function automatic logic [AW-1:0] cell_addr(input logic [YW-1:0] row, input logic [XW-1:0] col);
        return AW'(row) * COLS_A + AW'(col);
    endfunction

    fill_state_e        state_q, state_d;
    logic [YW-1:0]      scroll_q, scroll_d;
    logic [AW-1:0]      fill_addr_q, fill_addr_d;
    logic [AW-1:0]      fill_end_q, fill_end_d;
    logic               disp_ok_q, disp_ok_d;
    logic               rvalid_q, rvalid_d;
    logic               rd_ok_q, rd_ok_d;
    logic [ENTRY_W-1:0] rdata_q, rdata_d;

    logic [YW:0]        ysum;
    logic [YW-1:0]      prow;
    logic               disp_in, host_in, host_acc;
    logic [AW-1:0]      disp_addr;
    logic               b_en, b_we;
    logic [AW-1:0]      b_addr;
    logic [ENTRY_W-1:0] b_wdata, a_rdata, b_rdata;

    // Logical row to physical row: the sum is below 2*ROWS, so one subtract suffices.
    always_comb begin
        ysum      = {1'b0, ytext} + {1'b0, scroll_q};
        prow      = (ysum >= ROWS_S) ? YW'(ysum - ROWS_S) : ysum[YW-1:0];
        disp_in   = ({1'b0, xtext} < COLS_X) && ({1'b0, ytext} < ROWS_S);
        disp_addr = disp_in ? cell_addr(prow, xtext) : '0;
        disp_ok_d = disp_in;
    end

    always_comb begin
        host_in  = ({1'b0, host.host_x} < COLS_X) && ({1'b0, host.host_y} < ROWS_S);
        host_acc = host.host_req && (state_q == ST_IDLE);
        rvalid_d = host_acc && !host.host_we;
        rd_ok_d  = host_in;
        // Fill writes are suppressed on a reset edge so an abort leaves no extra cell.
        if (state_q != ST_IDLE) begin
            b_en    = !reset;
            b_we    = 1'b1;
            b_addr  = fill_addr_q;
            b_wdata = FILL_VALUE;
        end else begin
            b_en    = host_acc && host_in;
            b_we    = host.host_we;
            b_addr  = cell_addr(host.host_y, host.host_x);
            b_wdata = host.host_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        scroll_d    = scroll_q;
        fill_addr_d = fill_addr_q;
        fill_end_d  = fill_end_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_clear) begin
                    state_d     = ST_CLEAR;
                    scroll_d    = '0;
                    fill_addr_d = '0;
                    fill_end_d  = LAST_CELL;
                end else if (cmd_scroll) begin
                    state_d     = ST_SCROLL;
                    scroll_d    = (scroll_q == LAST_ROW) ? '0 : scroll_q + YW'(1);
                    fill_addr_d = cell_addr(scroll_q, '0);
                    fill_end_d  = cell_addr(scroll_q, LAST_COL);
                end
            end
            default: begin
                if (fill_addr_q == fill_end_q) state_d = ST_IDLE;
                else                            fill_addr_d = fill_addr_q + AW'(1);
            end
        endcase
    end

    always_comb begin
        host.host_rdata = rvalid_q ? (rd_ok_q ? b_rdata : '0) : rdata_q;
        rdata_d         = host.host_rdata;
        host.host_rvalid = rvalid_q;
        host.host_ready  = (state_q == ST_IDLE);
        entry            = disp_ok_q ? a_rdata : '0;
        busy             = (state_q != ST_IDLE);
        scroll           = scroll_q;
        dbg_state        = state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            scroll_q    <= '0;
            fill_addr_q <= '0;
            fill_end_q  <= '0;
            disp_ok_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rd_ok_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            scroll_q    <= scroll_d;
            fill_addr_q <= fill_addr_d;
            fill_end_q  <= fill_end_d;
            disp_ok_q   <= disp_ok_d;
            rvalid_q    <= rvalid_d;
            rd_ok_q     <= rd_ok_d;
            rdata_q     <= rdata_d;
        end
    end

    text_dpram #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (CELLS),
        .AW      (AW)
    ) u_ram (
        .clk       (clk),
        .a_addr    (disp_addr),
        .a_rdata_q (a_rdata),
        .b_en      (b_en),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdata_q (b_rdata)
    );
endmodule

// File: tb/tb_text_memory_ctrl.sv
// Self-checking bench for text_memory_ctrl: vector table, directed fill sequences, random traffic.
module tb_text_memory_ctrl;
    import text_memory_ctrl_pkg::*;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int EW   = 24;
    localparam int XW   = 7;
    localparam int YW   = 5;
    localparam logic [EW-1:0] FILL = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic [XW-1:0] xtext;
    logic [YW-1:0] ytext;
    logic [EW-1:0] entry;
    logic          cmd_clear, cmd_scroll, busy;
    logic [YW-1:0] scroll;
    fill_state_e   dbg_state;

    text_memory_ctrl_if #(.COLS(COLS), .ROWS(ROWS), .ENTRY_W(EW)) hif ();

    text_memory_ctrl #(.COLS(COLS), .ROWS(ROWS), .ENTRY_W(EW), .FILL_VALUE(FILL)) dut (
        .clk        (clk),
        .reset      (reset),
        .xtext      (xtext),
        .ytext      (ytext),
        .entry      (entry),
        .host       (hif),
        .cmd_clear  (cmd_clear),
        .cmd_scroll (cmd_scroll),
        .busy       (busy),
        .scroll     (scroll),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          we;
        int            x;
        int            y;
        logic [EW-1:0] d;
        logic [EW-1:0] exp;
    } vec_t;

    vec_t          vecs [11];
    logic [EW-1:0] mdl [ROWS][COLS];
    int            scr_m;
    logic [EW-1:0] exp_q [$];
    int            tests_run = 0;
    int            tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] model_rd(input int x, input int y);
        if (x >= COLS || y >= ROWS) return '0;
        return mdl[y][x];
    endfunction

    function automatic logic [EW-1:0] model_disp(input int x, input int y);
        if (x >= COLS || y >= ROWS) return '0;
        return mdl[(y + scr_m) % ROWS][x];
    endfunction

    task automatic model_fill_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mdl[r][c] = FILL;
    endtask

    task automatic host_write(input int x, input int y, input logic [EW-1:0] d);
        hif.host_req   = 1'b1;
        hif.host_we    = 1'b1;
        hif.host_x     = XW'(x);
        hif.host_y     = YW'(y);
        hif.host_wdata = d;
        tick();
        hif.host_req   = 1'b0;
        hif.host_we    = 1'b0;
        if (x < COLS && y < ROWS) mdl[y][x] = d;
    endtask

    task automatic host_read_raw(input int x, input int y, output logic v, output logic [EW-1:0] d);
        hif.host_req = 1'b1;
        hif.host_we  = 1'b0;
        hif.host_x   = XW'(x);
        hif.host_y   = YW'(y);
        tick();
        hif.host_req = 1'b0;
        v = hif.host_rvalid;
        d = hif.host_rdata;
    endtask

    task automatic host_read(input int x, input int y, input logic [EW-1:0] exp);
        logic          v;
        logic [EW-1:0] d, e;
        exp_q.push_back(exp);
        host_read_raw(x, y, v, d);
        e = exp_q.pop_front();
        chk("rd_rvalid", 32'(v), 32'd1);
        chk("rd_data", 32'(d), 32'(e));
    endtask

    task automatic check_all(input string name);
        int            errs = 0;
        logic          v;
        logic [EW-1:0] d;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                host_read_raw(c, r, v, d);
                if (v !== 1'b1 || d !== mdl[r][c]) errs++;
            end
        chk(name, errs, 0);
    endtask

    task automatic disp_check(input string name, input int x, input int y);
        xtext = XW'(x);
        ytext = YW'(y);
        tick();
        chk(name, 32'(entry), 32'(model_disp(x, y)));
    endtask

    task automatic disp_row(input string name, input int y);
        int errs = 0;
        for (int c = 0; c < COLS; c++) begin
            xtext = XW'(c);
            ytext = YW'(y);
            tick();
            if (entry !== model_disp(c, y)) errs++;
        end
        chk(name, errs, 0);
    endtask

    // Issue a command (optionally with a host write on the same edge) and time the busy window.
    task automatic run_cmd(input string name, input logic clr, input logic scl, input int exp_busy,
                           input logic do_wr, input int wx, input int wy, input logic [EW-1:0] wd);
        int n = 0;
        int bad_ready = 0;
        int row;
        cmd_clear  = clr;
        cmd_scroll = scl;
        if (do_wr) begin
            hif.host_req   = 1'b1;
            hif.host_we    = 1'b1;
            hif.host_x     = XW'(wx);
            hif.host_y     = YW'(wy);
            hif.host_wdata = wd;
            chk({name, "_ready_with_cmd"}, 32'(hif.host_ready), 32'd1);
        end
        tick();
        cmd_clear    = 1'b0;
        cmd_scroll   = 1'b0;
        hif.host_req = 1'b0;
        hif.host_we  = 1'b0;
        if (do_wr && wx < COLS && wy < ROWS) mdl[wy][wx] = wd;
        if (clr) begin
            model_fill_all();
            scr_m = 0;
        end else if (scl) begin
            row   = scr_m;
            scr_m = (scr_m + 1) % ROWS;
            for (int c = 0; c < COLS; c++) mdl[row][c] = FILL;
        end
        while (busy === 1'b1 && n < 3000) begin
            if (hif.host_ready !== 1'b0) bad_ready++;
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, n, exp_busy);
        chk({name, "_ready_low"}, bad_ready, 0);
        chk({name, "_ready_after"}, 32'(hif.host_ready), 32'd1);
        chk({name, "_scroll"}, 32'(scroll), 32'(scr_m));
    endtask

    initial begin
        int n;
        int op, x, y;
        logic [EW-1:0] d;

        vecs[0]  = '{we: 1'b1, x: 5,  y: 2,  d: 24'hABCDEF, exp: 24'h000000};
        vecs[1]  = '{we: 1'b0, x: 5,  y: 2,  d: 24'h000000, exp: 24'hABCDEF};
        vecs[2]  = '{we: 1'b1, x: 0,  y: 0,  d: 24'h123456, exp: 24'h000000};
        vecs[3]  = '{we: 1'b1, x: 80, y: 0,  d: 24'hFFFFFF, exp: 24'h000000};
        vecs[4]  = '{we: 1'b1, x: 0,  y: 30, d: 24'hEEEEEE, exp: 24'h000000};
        vecs[5]  = '{we: 1'b0, x: 80, y: 0,  d: 24'h000000, exp: 24'h000000};
        vecs[6]  = '{we: 1'b0, x: 0,  y: 30, d: 24'h000000, exp: 24'h000000};
        vecs[7]  = '{we: 1'b0, x: 0,  y: 1,  d: 24'h000000, exp: 24'h000000};
        vecs[8]  = '{we: 1'b0, x: 0,  y: 0,  d: 24'h000000, exp: 24'h123456};
        vecs[9]  = '{we: 1'b1, x: 79, y: 29, d: 24'h654321, exp: 24'h000000};
        vecs[10] = '{we: 1'b0, x: 79, y: 29, d: 24'h000000, exp: 24'h654321};

        reset = 1'b1;
        xtext = '0;
        ytext = '0;
        cmd_clear = 1'b0;
        cmd_scroll = 1'b0;
        hif.host_req = 1'b0;
        hif.host_we = 1'b0;
        hif.host_x = '0;
        hif.host_y = '0;
        hif.host_wdata = '0;
        scr_m = 0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_entry", 32'(entry), 32'd0);
        chk("rst_rvalid", 32'(hif.host_rvalid), 32'd0);
        chk("rst_rdata", 32'(hif.host_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_scroll", 32'(scroll), 32'd0);
        chk("rst_ready", 32'(hif.host_ready), 32'd1);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        run_cmd("init_clear", 1'b1, 1'b0, COLS * ROWS, 1'b0, 0, 0, '0);
        check_all("init_clear_all");

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) host_write(vecs[i].x, vecs[i].y, vecs[i].d);
            else            host_read(vecs[i].x, vecs[i].y, vecs[i].exp);
        end
        tick();
        chk("rvalid_pulse_drop", 32'(hif.host_rvalid), 32'd0);
        chk("rdata_hold", 32'(hif.host_rdata), 32'h654321);
        disp_check("disp_5_2", 5, 2);
        chk("disp_5_2_const", 32'(entry), 32'hABCDEF);
        disp_check("disp_x_oor", 100, 2);
        disp_check("disp_y_oor", 5, 30);
        check_all("oor_write_no_change");

        for (int c = 0; c < COLS; c++) begin
            host_write(c, 0, 24'h100000 + EW'(c));
            host_write(c, 1, 24'h200000 + EW'(c));
        end
        run_cmd("scroll1", 1'b0, 1'b1, COLS, 1'b0, 0, 0, '0);
        chk("scroll1_is_1", 32'(scroll), 32'd1);
        disp_check("disp_old_row1", 7, 0);
        chk("disp_old_row1_const", 32'(entry), 32'h200007);
        disp_row("disp_row0_is_old_row1", 0);
        disp_row("disp_bottom_blank", 29);

        run_cmd("scroll_hostwr_fillrow", 1'b0, 1'b1, COLS, 1'b1, 3, scr_m, 24'h777777);
        run_cmd("scroll_hostwr_other", 1'b0, 1'b1, COLS, 1'b1, 4, (scr_m + 5) % ROWS, 24'h888888);
        host_read(3, 1, model_rd(3, 1));
        host_read(4, (scr_m + 4) % ROWS, model_rd(4, (scr_m + 4) % ROWS));

        // Clear pulsed in the middle of a scroll must be ignored.
        cmd_scroll = 1'b1;
        tick();
        cmd_scroll = 1'b0;
        for (int c = 0; c < COLS; c++) mdl[scr_m][c] = FILL;
        scr_m = (scr_m + 1) % ROWS;
        repeat (10) tick();
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        n = 11;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            tick();
        end
        chk("cmd_while_busy_cycles", n, COLS);
        chk("cmd_while_busy_scroll", 32'(scroll), 32'(scr_m));

        while (scr_m != ROWS - 1) run_cmd("scroll_walk", 1'b0, 1'b1, COLS, 1'b0, 0, 0, '0);
        host_write(7, 0, 24'h5A5A5A);
        disp_check("disp_at_scroll29", 7, 1);
        run_cmd("scroll_wrap", 1'b0, 1'b1, COLS, 1'b0, 0, 0, '0);
        chk("scroll_wrap_zero", 32'(scroll), 32'd0);
        disp_check("disp_after_wrap", 7, 0);

        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 19);
            x  = $urandom_range(0, COLS + 2);
            y  = $urandom_range(0, ROWS + 1);
            d  = EW'($urandom);
            if (op < 7)       host_write(x, y, d);
            else if (op < 13) host_read(x, y, model_rd(x, y));
            else if (op < 19) disp_check("rand_disp", x, y);
            else              run_cmd("rand_scroll", 1'b0, 1'b1, COLS, 1'b0, 0, 0, '0);
        end
        check_all("rand_all");

        run_cmd("pre_clear_scroll", 1'b0, 1'b1, COLS, 1'b0, 0, 0, '0);
        host_write(10, 10, 24'h0F0F0F);
        run_cmd("clear_and_scroll", 1'b1, 1'b1, COLS * ROWS, 1'b0, 0, 0, '0);
        chk("clear_and_scroll_zero", 32'(scroll), 32'd0);
        check_all("clear_and_scroll_all");

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) host_write(c, r, EW'(r * COLS + c + 1));
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_scroll", 32'(scroll), 32'd0);
        chk("abort_ready", 32'(hif.host_ready), 32'd1);
        chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        for (int a = 0; a < 100; a++) mdl[a / COLS][a % COLS] = FILL;
        scr_m = 0;
        check_all("abort_partial_fill");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
